// File: rtl/spi_slave.sv
// Byte-oriented SPI slave: oversampled SCK/CS/MOSI, MSB-first, all four SPI modes.
// Optional macro SPI_SLAVE_UNDERRUN_EN adds tx_underrun_o (IDLE_BYTE substitution pulse).
//
//   state  | meaning
//   IDLE   | CS high; SCK edges ignored; MISO not driven
//   ACTIVE | CS low; sampling MOSI / shifting MISO on classified SCK edges
module spi_slave #(
    parameter int unsigned SPI_MODE  = 0,
    parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
    input  logic       clk_i,
    input  logic       reset_l_i,
    input  logic [7:0] tx_data_byte_i,
    input  logic       tx_data_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_byte_o,
    output logic       rx_data_valid_o,
    input  logic       spi_clk_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
`ifdef SPI_SLAVE_UNDERRUN_EN
    output logic       tx_underrun_o,
`endif
    output logic       spi_miso_oe_o
);

    localparam logic [1:0] MODE = 2'(SPI_MODE);
    localparam logic       CPOL = MODE[1];
    localparam logic       CPHA = MODE[0];

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_vld_q, rx_vld_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       reload_pend_q, reload_pend_d;
    logic       skip_q, skip_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       underrun_q, underrun_d;
`endif

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, byte_start;

    // CS chain resets low so that a CS already low at reset release never
    // looks like a falling edge; a fresh high-to-low transition is required.
    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            sck_meta_q  <= CPOL;
            sck_sync_q  <= CPOL;
            sck_prev_q  <= CPOL;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= spi_clk_i;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= spi_cs_n_i;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= spi_mosi_i;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign lead_edge   = (sck_prev_q == CPOL) && (sck_sync_q != CPOL);
    assign trail_edge  = (sck_prev_q != CPOL) && (sck_sync_q == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q && !cs_sync_q;
    assign cs_rise     = !cs_prev_q && cs_sync_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        rx_byte_d     = rx_byte_q;
        rx_vld_d      = 1'b0;
        miso_d        = miso_q;
        oe_d          = oe_q;
        reload_pend_d = reload_pend_q;
        skip_d        = skip_q;
        byte_start    = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_d    = 1'b0;
`endif

        if (tx_data_valid_i && !hold_vld_q) begin
            hold_d     = tx_data_byte_i;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d       = ACTIVE;
                    byte_start    = 1'b1;
                    bit_cnt_d     = 3'd0;
                    oe_d          = 1'b1;
                    skip_d        = CPHA;
                    reload_pend_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_sync_q};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_d     = {rx_shift_q, mosi_sync_q};
                        rx_vld_d      = 1'b1;
                        reload_pend_d = 1'b1;
                    end
                end
                // The shift edge after a completed byte becomes the reload.
                if (shift_edge) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (reload_pend_q) begin
                        byte_start    = 1'b1;
                        reload_pend_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end
                end
                // A byte finishing on this same edge keeps its rx_vld_d pulse.
                if (cs_rise) begin
                    state_d       = IDLE;
                    bit_cnt_d     = 3'd0;
                    oe_d          = 1'b0;
                    reload_pend_d = 1'b0;
                    skip_d        = 1'b0;
                    byte_start    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_start) begin
            if (hold_vld_q) begin
                tx_shift_d = hold_q;
                miso_d     = hold_q[7];
                hold_vld_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                miso_d     = IDLE_BYTE[7];
`ifdef SPI_SLAVE_UNDERRUN_EN
                underrun_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_l_i) begin
        if (!reset_l_i) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 7'd0;
            tx_shift_q    <= 8'd0;
            hold_q        <= 8'd0;
            hold_vld_q    <= 1'b0;
            rx_byte_q     <= 8'd0;
            rx_vld_q      <= 1'b0;
            miso_q        <= 1'b0;
            oe_q          <= 1'b0;
            reload_pend_q <= 1'b0;
            skip_q        <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
            underrun_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            rx_byte_q     <= rx_byte_d;
            rx_vld_q      <= rx_vld_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            reload_pend_q <= reload_pend_d;
            skip_q        <= skip_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
            underrun_q    <= underrun_d;
`endif
        end
    end

    assign tx_ready_o      = !hold_vld_q;
    assign rx_data_byte_o  = rx_byte_q;
    assign rx_data_valid_o = rx_vld_q;
    assign spi_miso_o      = miso_q;
    assign spi_miso_oe_o   = oe_q;
`ifdef SPI_SLAVE_UNDERRUN_EN
    assign tx_underrun_o   = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one instance per SPI mode, a bench-side SPI master,
// and monitors that pop expected rx / master-received bytes from queues.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk;
    logic       rst_l;
    logic [7:0] tx_data  [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic [7:0] rx_byte  [4];
    logic       rx_valid [4];
    logic       sck      [4];
    logic       cs_n     [4];
    logic       mosi     [4];
    logic       miso     [4];
    logic       miso_oe  [4];
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       und      [4];
    int         und_cnt  [4];
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_exp  [$];
    logic [7:0] mrx_exp [$];
    logic [7:0] mrx_byte;
    logic       mrx_stb = 1'b0;
    logic       prev_valid [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g), .IDLE_BYTE(8'hFF)) u_dut (
            .clk_i           (clk),
            .reset_l_i       (rst_l),
            .tx_data_byte_i  (tx_data[g]),
            .tx_data_valid_i (tx_valid[g]),
            .tx_ready_o      (tx_ready[g]),
            .rx_data_byte_o  (rx_byte[g]),
            .rx_data_valid_o (rx_valid[g]),
            .spi_clk_i       (sck[g]),
            .spi_cs_n_i      (cs_n[g]),
            .spi_mosi_i      (mosi[g]),
            .spi_miso_o      (miso[g]),
`ifdef SPI_SLAVE_UNDERRUN_EN
            .tx_underrun_o   (und[g]),
`endif
            .spi_miso_oe_o   (miso_oe[g])
        );
    end

    function automatic logic cpol_of(input int m);
        return (m >= 2);
    endfunction

    function automatic logic cpha_of(input int m);
        return (m % 2 == 1);
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rx monitor: every valid pulse must match the next expected byte and last one cycle
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rst_l && rx_valid[m]) begin
                checks++;
                if (rx_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected dut%0d: got %0h expected no pulse", m, rx_byte[m]);
                end else begin
                    logic [7:0] e;
                    e = rx_exp.pop_front();
                    if (rx_byte[m] !== e) begin
                        errors++;
                        $display("FAIL rx_byte dut%0d: got %0h expected %0h", m, rx_byte[m], e);
                    end
                end
                checks++;
                if (prev_valid[m] !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_valid_width dut%0d: got 2+ cycles expected 1", m);
                end
            end
            prev_valid[m] = rx_valid[m];
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++)
            if (rst_l && und[m]) und_cnt[m]++;
    end
`endif

    // master-side monitor: bytes the bench master shifted in from MISO
    initial begin
        forever begin
            @(mrx_stb);
            checks++;
            if (mrx_exp.size() == 0) begin
                errors++;
                $display("FAIL miso_unexpected: got %0h expected none", mrx_byte);
            end else begin
                logic [7:0] e;
                e = mrx_exp.pop_front();
                if (mrx_byte !== e) begin
                    errors++;
                    $display("FAIL miso_byte: got %0h expected %0h", mrx_byte, e);
                end
            end
        end
    end

    task automatic load(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_data[m]  = b;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    task automatic cs_low(input int m);
        @(negedge clk);
        cs_n[m] = 1'b0;
        clks(6);
    endtask

    task automatic cs_high(input int m);
        clks(4);
        cs_n[m] = 1'b1;
        clks(8);
    endtask

    // SCK half period = 4 clk cycles; master samples MISO just before its sample edge
    task automatic xfer(input int m, input logic [7:0] tx, input int nbits);
        logic       cpol, cpha;
        logic [7:0] rcv;
        cpol = cpol_of(m);
        cpha = cpha_of(m);
        rcv  = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[m] = tx[7-i];
                clks(4);
                rcv = {rcv[6:0], miso[m]};
                sck[m] = ~cpol;
                clks(4);
                sck[m] = cpol;
            end else begin
                sck[m]  = ~cpol;
                mosi[m] = tx[7-i];
                clks(4);
                rcv = {rcv[6:0], miso[m]};
                sck[m] = cpol;
                clks(4);
            end
        end
        if (nbits == 8) begin
            mrx_byte = rcv;
            mrx_stb  = ~mrx_stb;
        end
    endtask

    task automatic wait_ready(input int m);
        int n;
        n = 0;
        while (!tx_ready[m] && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready[m]}, 32'd1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst_l = 1'b0;
        for (int m = 0; m < 4; m++) begin
            tx_data[m]    = 8'd0;
            tx_valid[m]   = 1'b0;
            sck[m]        = cpol_of(m);
            cs_n[m]       = 1'b1;
            mosi[m]       = 1'b0;
            prev_valid[m] = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
            und_cnt[m]    = 0;
`endif
        end
        clks(3);
        for (int m = 0; m < 4; m++) begin
            chk("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
            chk("rst_rx_byte", {24'd0, rx_byte[m]}, 32'd0);
            chk("rst_rx_valid", {31'd0, rx_valid[m]}, 32'd0);
            chk("rst_miso", {31'd0, miso[m]}, 32'd0);
            chk("rst_miso_oe", {31'd0, miso_oe[m]}, 32'd0);
        end
        rst_l = 1'b1;
        clks(8);

        // mode 0: preload A5, ignored second load, master sends 3C
        load(0, 8'hA5);
        chk("m0_ready_after_load", {31'd0, tx_ready[0]}, 32'd0);
        load(0, 8'h55);
        cs_low(0);
        chk("m0_ready_after_csfall", {31'd0, tx_ready[0]}, 32'd1);
        chk("m0_oe_active", {31'd0, miso_oe[0]}, 32'd1);
        chk("m0_miso_bit7", {31'd0, miso[0]}, 32'd1);
        rx_exp.push_back(8'h3C);
        mrx_exp.push_back(8'hA5);
        xfer(0, 8'h3C, 8);
        cs_high(0);
        chk("m0_oe_idle", {31'd0, miso_oe[0]}, 32'd0);

        // modes 1..3: tx 81, master sends 7E
        for (int m = 1; m < 4; m++) begin
            load(m, 8'h81);
            cs_low(m);
            rx_exp.push_back(8'h7E);
            mrx_exp.push_back(8'h81);
            xfer(m, 8'h7E, 8);
            cs_high(m);
        end

        // two-byte frame on mode 0 with reload during byte 0
        load(0, 8'h11);
        cs_low(0);
        wait_ready(0);
        load(0, 8'h22);
        rx_exp.push_back(8'hAA);
        mrx_exp.push_back(8'h11);
        xfer(0, 8'hAA, 8);
        rx_exp.push_back(8'h55);
        mrx_exp.push_back(8'h22);
        xfer(0, 8'h55, 8);
        cs_high(0);

        // mode 1 with empty holding register: IDLE_BYTE on MISO
        cs_low(1);
        rx_exp.push_back(8'h5A);
        mrx_exp.push_back(8'hFF);
        xfer(1, 8'h5A, 8);
        cs_high(1);
`ifdef SPI_SLAVE_UNDERRUN_EN
        chk("underrun_count", und_cnt[1], 32'd1);
`endif

        // partial frame on mode 0, then a full frame
        cs_low(0);
        xfer(0, 8'hF0, 5);
        cs_high(0);
        chk("partial_oe", {31'd0, miso_oe[0]}, 32'd0);
        chk("partial_rx_byte_kept", {24'd0, rx_byte[0]}, 32'h55);
        load(0, 8'h96);
        cs_low(0);
        rx_exp.push_back(8'h69);
        mrx_exp.push_back(8'h96);
        xfer(0, 8'h69, 8);
        cs_high(0);

        // reset mid-byte on mode 3, then a clean frame
        load(3, 8'h3A);
        cs_low(3);
        load(3, 8'h44);
        chk("m3_ready_held", {31'd0, tx_ready[3]}, 32'd0);
        xfer(3, 8'hC3, 4);
        chk("m3_oe_midbyte", {31'd0, miso_oe[3]}, 32'd1);
        rst_l = 1'b0;
        #1;
        chk("midrst_tx_ready", {31'd0, tx_ready[3]}, 32'd1);
        chk("midrst_rx_byte", {24'd0, rx_byte[3]}, 32'd0);
        chk("midrst_rx_valid", {31'd0, rx_valid[3]}, 32'd0);
        chk("midrst_miso", {31'd0, miso[3]}, 32'd0);
        chk("midrst_miso_oe", {31'd0, miso_oe[3]}, 32'd0);
        cs_n[3] = 1'b1;
        sck[3]  = cpol_of(3);
        clks(3);
        rst_l = 1'b1;
        clks(8);
        chk("postrst_oe", {31'd0, miso_oe[3]}, 32'd0);
        load(3, 8'hE7);
        cs_low(3);
        rx_exp.push_back(8'h18);
        mrx_exp.push_back(8'hE7);
        xfer(3, 8'h18, 8);
        cs_high(3);

        clks(10);
        chk("rx_queue_drained", rx_exp.size(), 32'd0);
        chk("miso_queue_drained", mrx_exp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Byte-oriented SPI slave (target). It is the far-end counterpart of spi_master and pairs with it in loopback benches.
- Oversamples the SPI clock, chip select and MOSI in the clk_i domain.
- Shifts received bits into a byte, presented as a one-cycle valid pulse, and drives MISO from a one-deep transmit holding register.
- MSB-first. All four SPI modes are supported.

Parameters:
- SPI_MODE, 0, {CPOL,CPHA} encoding 0..3. Idle SCK level = CPOL. CPHA=0 samples on the leading edge; CPHA=1 samples on the trailing edge.
- IDLE_BYTE, 8'hFF, byte shifted out when the holding register is empty at a byte start.

Ports:
- clk_i  input  1  system clock
- reset_l_i  input  1  asynchronous active-low reset
- tx_data_byte_i  input  8  byte to send on MISO
- tx_data_valid_i  input  1  load strobe; accepted when tx_ready_o=1
- tx_ready_o  output  1  holding register empty
- rx_data_byte_o  output  8  last received byte
- rx_data_valid_o  output  1  one-cycle pulse: rx_data_byte_o is new
- spi_clk_i  input  1  SCK from master (asynchronous)
- spi_cs_n_i  input  1  chip select, active low (asynchronous)
- spi_mosi_i  input  1  MOSI (asynchronous)
- spi_miso_o  output  1  MISO data
- spi_miso_oe_o  output  1  MISO drive enable; high only while CS is low

Behaviour:
- Reset (reset_l_i=0, async): tx_ready_o=1, rx_data_byte_o=0, rx_data_valid_o=0, spi_miso_o=0, spi_miso_oe_o=0, holding register empty, bit counter=0, state IDLE.
- Synchronizers:
  - spi_clk_i, spi_cs_n_i and spi_mosi_i each pass through a 2-FF synchronizer. A third register provides edge detection.
  - Edge detect latency is 3 clk_i cycles.
  - Requirement: each SCK high and low phase is at least 4 clk_i cycles (SCK at most clk_i/8).
- Edge classification: leading edge = transition away from CPOL level; trailing edge = return to CPOL level.
  - CPHA=0: sample = leading, shift = trailing.
  - CPHA=1: shift = leading, sample = trailing.
  - In CPHA=1, the first leading edge after CS falls performs no shift.
- TX holding register:
  - tx_data_valid_i && tx_ready_o captures tx_data_byte_i. tx_ready_o falls on the next cycle.
  - tx_data_valid_i while tx_ready_o=0 is ignored; the held byte is not overwritten.
  - tx_ready_o rises in the cycle after the holding register is consumed.
- State machine:
  - IDLE (synced CS high) -> ACTIVE on synced CS falling edge.
    - Byte start: shift register loads the holding byte, or IDLE_BYTE if empty.
    - bit counter = 0, spi_miso_oe_o=1, spi_miso_o = bit 7 of the loaded byte.
  - ACTIVE:
    - Each sample edge: rx shift register takes synced MOSI into bit 0; bit counter increments.
    - Each shift edge: tx shift register shifts left; spi_miso_o = new bit 7.
    - After the 8th sample edge:
      - Next cycle: rx_data_byte_o updates and rx_data_valid_o pulses for exactly 1 cycle.
      - Counter wraps to 0.
      - Next byte start: tx shift register reloads (holding byte or IDLE_BYTE), and spi_miso_o takes the new bit 7 on that reload.
      - The tx shift edge coincident with the byte boundary is consumed by the reload.
  - ACTIVE -> IDLE on synced CS rising edge.
    - Partial byte (counter != 0) is discarded: no rx_data_valid_o, counter cleared.
    - spi_miso_oe_o=0 in the same cycle.
    - An unsent byte already moved into the shift register is lost. The holding register is untouched.
- Simultaneous events:
  - A CS rising edge in the same cycle as the 8th sample edge completes the byte: rx_data_valid_o still pulses.
  - A tx load in the same cycle as holding-register consumption is not accepted, because tx_ready_o was 0 that cycle.
- SCK edges while CS is high are ignored.
- Asserting reset mid-frame returns to IDLE immediately. After release, a new CS falling edge is required before any activity.

Optional Feature:
- Macro SPI_SLAVE_UNDERRUN_EN.
- Defined: adds output tx_underrun_o (1 bit, reset 0). It pulses high for 1 cycle whenever a byte start loads IDLE_BYTE because the holding register was empty.
- Undefined: port absent; IDLE_BYTE substitution occurs silently.

Test Plan:
- Mode 0, SCK=clk/8: preload 8'hA5, CS low, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_byte_o=8'h3C with a single-cycle rx_data_valid_o; tx_ready_o=1 after the CS-fall load.
- Modes 1, 2, 3: same exchange (tx 8'h81, master 8'h7E) -> rx 8'h7E, master receives 8'h81 in each mode.
- Two-byte frame without CS deassert: preload 8'h11, reload 8'h22 while tx_ready_o=1 during byte 0 -> MISO carries 8'h11 then 8'h22; two rx_data_valid_o pulses.
- Empty holding register at byte start -> MISO sends 8'hFF; with SPI_SLAVE_UNDERRUN_EN, tx_underrun_o pulses once.
- CS deasserted after 5 SCK cycles -> no rx_data_valid_o; spi_miso_oe_o=0; next full frame receives correctly.
- Reset asserted mid-byte -> all outputs at reset values within the same cycle; tx_ready_o=1; a subsequent frame works.
